// File: rtl/unidade_pc.sv
// unidade_pc
// Fetch-side program counter stage with IN-instruction stall, syscall trap,
// kernel swap into user mode and round-robin preemption on quantum expiry.
//
// Ports
//   clock, reset   rising-edge clock, synchronous active-high reset
//   Opcode         opcode of the instruction at PC
//   Halt           IN instruction in progress (wait for Confirm)
//   Desvio         control-flow instruction; 0 forces sequential PC
//   TypeJR         jump to register
//   Syscall_Sign   system call request
//   Zero           ALU equality result for BEQ/BNE
//   Imediato       absolute jump/branch target
//   RegJR          register operand, low PC_WIDTH bits used as target
//   Confirm        synchronized input-confirm button level
//   PC, EPC        current and saved return address
//   UserMode       1 while a user process runs
//   Stall          PC frozen waiting for Confirm
//   InAck          one-cycle pulse, register file captures the input value
//   Preempt        one-cycle pulse on quantum expiry
module unidade_pc #(
    parameter int                  PC_WIDTH     = 10,
    parameter logic [PC_WIDTH-1:0] KERNEL_ENTRY = '0,
    parameter int                  QUANTUM      = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [5:0]          Opcode,
    input  logic                Halt,
    input  logic                Desvio,
    input  logic                TypeJR,
    input  logic                Syscall_Sign,
    input  logic                Zero,
    input  logic [PC_WIDTH-1:0] Imediato,
    input  logic [31:0]         RegJR,
    input  logic                Confirm,
    output logic [PC_WIDTH-1:0] PC,
    output logic [PC_WIDTH-1:0] EPC,
    output logic                UserMode,
    output logic                Stall,
    output logic                InAck,
    output logic                Preempt
);

    typedef enum logic {RUN, WAIT_IN} state_t;

    localparam logic [5:0] OP_KERNEL_SWAP = 6'b100001;
    localparam logic [5:0] OP_JUMP        = 6'b000101;
    localparam logic [5:0] OP_BEQ         = 6'b001010;
    localparam logic [5:0] OP_BNE         = 6'b001011;
    localparam logic [7:0] QUANTUM_INIT   = 8'(QUANTUM);

    state_t              state_q, state_n;
    logic [PC_WIDTH-1:0] pc_q, pc_n;
    logic [PC_WIDTH-1:0] epc_q, epc_n;
    logic                user_q, user_n;
    logic [7:0]          count_q, count_n;
    logic                confirm_d;

    logic [PC_WIDTH-1:0] seq_pc;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] reg_target;
    logic                swap;
    logic                retire;
    logic                confirm_edge;
    logic                in_ack;
    logic                preempt;
    logic                unused_regjr_high;

    assign seq_pc            = pc_q + PC_WIDTH'(1);
    assign reg_target        = RegJR[PC_WIDTH-1:0];
    assign unused_regjr_high = ^RegJR[31:PC_WIDTH];
    assign confirm_edge      = Confirm & ~confirm_d;

    // A kernel swap only counts as a control-flow instruction issued from kernel
    // mode; in user mode the same opcode falls through as a NOP.
    assign swap = Desvio && (Opcode == OP_KERNEL_SWAP) && !user_q;

    // Branch resolution for an instruction retiring in RUN.
    always_comb begin
        target = seq_pc;
        if (Desvio) begin
            if (swap) begin
                target = reg_target;
            end else if (TypeJR) begin
                target = reg_target;
            end else if (Opcode == OP_JUMP) begin
                target = Imediato;
            end else if (((Opcode == OP_BEQ) && Zero) || ((Opcode == OP_BNE) && !Zero)) begin
                target = Imediato;
            end
        end
    end

    // Next-state logic. The quantum check runs after the per-state decision so
    // that a preempted instruction has already resolved its own successor,
    // which then becomes the saved return address.
    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        epc_n   = epc_q;
        user_n  = user_q;
        count_n = count_q;
        retire  = 1'b0;
        in_ack  = 1'b0;
        preempt = 1'b0;

        case (state_q)
            RUN: begin
                if (Halt) begin
                    state_n = WAIT_IN;
                end else if (Syscall_Sign && user_q) begin
                    epc_n   = seq_pc;
                    pc_n    = KERNEL_ENTRY;
                    user_n  = 1'b0;
                    count_n = 8'd0;
                end else begin
                    retire = 1'b1;
                    pc_n   = target;
                    if (swap) begin
                        user_n  = 1'b1;
                        count_n = QUANTUM_INIT;
                    end
                end
            end
            WAIT_IN: begin
                if (confirm_edge) begin
                    in_ack  = 1'b1;
                    retire  = 1'b1;
                    pc_n    = seq_pc;
                    state_n = RUN;
                end
            end
            default: state_n = RUN;
        endcase

        if (retire && user_q && (count_q != 8'd0)) begin
            if (count_q == 8'd1) begin
                epc_n   = pc_n;
                pc_n    = KERNEL_ENTRY;
                user_n  = 1'b0;
                count_n = 8'd0;
                preempt = 1'b1;
            end else begin
                count_n = count_q - 8'd1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RUN;
            pc_q      <= '0;
            epc_q     <= '0;
            user_q    <= 1'b0;
            count_q   <= 8'd0;
            confirm_d <= 1'b0;
        end else begin
            state_q   <= state_n;
            pc_q      <= pc_n;
            epc_q     <= epc_n;
            user_q    <= user_n;
            count_q   <= count_n;
            confirm_d <= Confirm;
        end
    end

    // Pulses are suppressed while reset is held so a reset cycle never
    // acknowledges input or signals a preemption.
    assign PC       = pc_q;
    assign EPC      = epc_q;
    assign UserMode = user_q;
    assign Stall    = (state_q == WAIT_IN) && !reset;
    assign InAck    = in_ack && !reset;
    assign Preempt  = preempt && !reset;

endmodule

// File: tb/tb_unidade_pc.sv
// tb_unidade_pc
// Drives unidade_pc with directed scenarios followed by random stimulus and
// compares every cycle against a behavioural model of the PC stage.
module tb_unidade_pc;

    localparam int PCW     = 10;
    localparam int PCMOD   = 1 << PCW;
    localparam int QUANTUM = 4;
    localparam int KENTRY  = 0;

    logic            clock = 1'b0;
    logic            reset;
    logic [5:0]      Opcode;
    logic            Halt, Desvio, TypeJR, Syscall_Sign, Zero, Confirm;
    logic [PCW-1:0]  Imediato;
    logic [31:0]     RegJR;
    logic [PCW-1:0]  PC, EPC;
    logic            UserMode, Stall, InAck, Preempt;

    int error_count = 0;
    int check_count = 0;

    // Model state
    int m_pc = 0;
    int m_epc = 0;
    bit m_user = 0;
    int m_quota = 0;
    bit m_waiting = 0;
    bit m_conf_prev = 0;

    // Most recently observed pulses, for directed checks
    logic seen_inack, seen_preempt;

    unidade_pc #(
        .PC_WIDTH(PCW),
        .KERNEL_ENTRY(10'(KENTRY)),
        .QUANTUM(QUANTUM)
    ) dut (
        .clock(clock),
        .reset(reset),
        .Opcode(Opcode),
        .Halt(Halt),
        .Desvio(Desvio),
        .TypeJR(TypeJR),
        .Syscall_Sign(Syscall_Sign),
        .Zero(Zero),
        .Imediato(Imediato),
        .RegJR(RegJR),
        .Confirm(Confirm),
        .PC(PC),
        .EPC(EPC),
        .UserMode(UserMode),
        .Stall(Stall),
        .InAck(InAck),
        .Preempt(Preempt)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock cycle: drive inputs, check the pulse outputs before the edge,
    // advance the model at the edge, check the registered outputs after it.
    task automatic applyStimulus(input bit rst, input int op, input bit halt, input bit desvio,
                                 input bit jr, input bit sys, input bit zero, input int imm,
                                 input int regjr, input bit conf);
        int n_pc, n_epc, n_quota;
        bit n_user, n_wait, retired, e_ack, e_pre;

        reset        = rst;
        Opcode       = 6'(op);
        Halt         = halt;
        Desvio       = desvio;
        TypeJR       = jr;
        Syscall_Sign = sys;
        Zero         = zero;
        Imediato     = PCW'(imm);
        RegJR        = 32'(regjr);
        Confirm      = conf;

        n_pc = m_pc; n_epc = m_epc; n_user = m_user; n_quota = m_quota; n_wait = m_waiting;
        retired = 0; e_ack = 0; e_pre = 0;

        if (!m_waiting) begin
            if (halt) begin
                n_wait = 1;
            end else if (sys && m_user) begin
                n_epc = (m_pc + 1) % PCMOD;
                n_pc = KENTRY;
                n_user = 0;
                n_quota = 0;
            end else begin
                retired = 1;
                if (!desvio)
                    n_pc = (m_pc + 1) % PCMOD;
                else if (op == 33 && !m_user) begin
                    n_pc = regjr & (PCMOD - 1);
                    n_user = 1;
                    n_quota = QUANTUM;
                end else if (jr)
                    n_pc = regjr & (PCMOD - 1);
                else if (op == 5)
                    n_pc = imm % PCMOD;
                else if ((op == 10 && zero) || (op == 11 && !zero))
                    n_pc = imm % PCMOD;
                else
                    n_pc = (m_pc + 1) % PCMOD;
            end
        end else if (conf && !m_conf_prev) begin
            e_ack = 1;
            retired = 1;
            n_wait = 0;
            n_pc = (m_pc + 1) % PCMOD;
        end

        if (retired && m_user) begin
            if (m_quota == 1) begin
                n_epc = n_pc;
                n_pc = KENTRY;
                n_user = 0;
                n_quota = 0;
                e_pre = 1;
            end else begin
                n_quota = m_quota - 1;
            end
        end

        if (rst) begin
            n_pc = 0; n_epc = 0; n_user = 0; n_quota = 0; n_wait = 0;
            e_ack = 0; e_pre = 0;
        end

        #1;
        seen_inack   = InAck;
        seen_preempt = Preempt;
        checkOutput("Stall", 32'(Stall), 32'(m_waiting && !rst));
        checkOutput("InAck", 32'(InAck), 32'(e_ack));
        checkOutput("Preempt", 32'(Preempt), 32'(e_pre));

        @(posedge clock);
        m_pc = n_pc; m_epc = n_epc; m_user = n_user; m_quota = n_quota; m_waiting = n_wait;
        m_conf_prev = rst ? 1'b0 : conf;
        #1;
        checkOutput("PC", 32'(PC), 32'(m_pc));
        checkOutput("EPC", 32'(EPC), 32'(m_epc));
        checkOutput("UserMode", 32'(UserMode), 32'(m_user));
        @(negedge clock);
    endtask

    task automatic plainOp(input bit desvio);
        applyStimulus(0, 0, 0, desvio, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic kernelSwap(input int where);
        applyStimulus(0, 33, 0, 1, 0, 0, 0, 0, where, 0);
    endtask

    initial begin
        int ops[6];
        ops = '{0, 5, 10, 11, 33, 8};

        // Reset and sequential stepping
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_pc", 32'(PC), 0);
        checkOutput("reset_user", 32'(UserMode), 0);
        for (int i = 1; i <= 5; i++) begin
            plainOp(0);
            checkOutput("seq_pc", 32'(PC), 32'(i));
        end

        // Branches, JR and wrap
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) plainOp(0);
        applyStimulus(0, 10, 0, 1, 0, 0, 1, 40, 0, 0);
        checkOutput("beq_taken", 32'(PC), 40);
        applyStimulus(0, 11, 0, 1, 0, 0, 1, 99, 0, 0);
        checkOutput("bne_not_taken", 32'(PC), 41);
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 0, 32'h0000_0123, 0);
        checkOutput("jr_target", 32'(PC), 32'h123);
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 0, 32'hFFFF_FFFF, 0);
        plainOp(0);
        checkOutput("wrap", 32'(PC), 0);
        applyStimulus(0, 5, 0, 0, 0, 0, 0, 77, 0, 0);
        checkOutput("desvio_low", 32'(PC), 1);

        // IN with Confirm held high on entry
        applyStimulus(0, 5, 0, 1, 0, 0, 0, 7, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
            checkOutput("in_hold_pc", 32'(PC), 7);
            checkOutput("in_no_ack", 32'(seen_inack), 0);
        end
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("in_ack", 32'(seen_inack), 1);
        checkOutput("in_done_pc", 32'(PC), 8);
        plainOp(0);

        // Kernel swap and quantum expiry
        kernelSwap(100);
        checkOutput("swap_user", 32'(UserMode), 1);
        for (int i = 0; i < QUANTUM; i++) plainOp(1);
        checkOutput("preempt_pulse", 32'(seen_preempt), 1);
        checkOutput("preempt_epc", 32'(EPC), 104);
        checkOutput("preempt_pc", 32'(PC), KENTRY);

        // User syscall
        kernelSwap(200);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("sys_epc", 32'(EPC), 201);
        checkOutput("sys_user", 32'(UserMode), 0);

        // Syscall at the expiring instruction
        kernelSwap(300);
        for (int i = 0; i < QUANTUM - 1; i++) plainOp(1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("sys_wins_preempt", 32'(seen_preempt), 0);
        checkOutput("sys_wins_epc", 32'(EPC), 304);

        // IN retiring at quantum expiry
        kernelSwap(500);
        for (int i = 0; i < QUANTUM - 1; i++) plainOp(1);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("in_expiry_ack", 32'(seen_inack), 1);
        checkOutput("in_expiry_pre", 32'(seen_preempt), 1);
        checkOutput("in_expiry_epc", 32'(EPC), 504);

        // Reset during WAIT_IN
        plainOp(0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        plainOp(0);
        checkOutput("reset_wait_pc", 32'(PC), 1);

        // Random stimulus
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom % 60) == 0,
                          ops[$urandom % 6],
                          ($urandom % 8) == 0,
                          ($urandom % 4) != 0,
                          ($urandom % 8) == 0,
                          ($urandom % 10) == 0,
                          $urandom % 2,
                          $urandom % PCMOD,
                          $urandom,
                          $urandom % 2);
        end

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
